// File: rtl/hc595_chain_tx_if.sv
// hc595_chain_tx_if: request/handshake and 595 pin bundle for hc595_chain_tx
interface hc595_chain_tx_if #(parameter int DATA_WIDTH = 16);
  logic [DATA_WIDTH-1:0] data;
  logic load, auto, busy, done, sh_cp, st_cp, ds;
  modport master(output data, load, auto, input busy, done, sh_cp, st_cp, ds);
  modport slave(input data, load, auto, output busy, done, sh_cp, st_cp, ds);
endinterface

// File: rtl/hc595_chain_tx.sv
// hc595_chain_tx: request-driven serial driver for a chain of 74HC595 shift registers
module hc595_chain_tx #(
  parameter int DATA_WIDTH  = 16,
  parameter int DIV_CNT_MAX = 4,
  parameter bit LSB_FIRST   = 0
) (
  input logic clk_i,
  input logic rst_i,
  hc595_chain_tx_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int DVW = DIV_CNT_MAX > 0 ? $clog2(DIV_CNT_MAX + 1) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t state_q, state_d;
  logic [DVW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d, sr_nx;
  logic sh_q, sh_d, st_q, st_d, ds_q, ds_d, busy_q, busy_d, done_q, done_d;
  logic start, tick, rise, fall, last_fall, latch_end;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      sh_q    <= 1'b0;
      st_q    <= 1'b0;
      ds_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      sh_q    <= sh_d;
      st_q    <= st_d;
      ds_q    <= ds_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    start     = state_q == IDLE && (bus.load || bus.auto);
    tick      = state_q != IDLE && div_q == DVW'(DIV_CNT_MAX);
    rise      = tick && state_q == SHIFT && !sh_q;
    fall      = tick && state_q == SHIFT && sh_q;
    last_fall = fall && cnt_q == CW'(DATA_WIDTH);
    latch_end = tick && state_q == LATCH;
    state_d   = state_q == IDLE ? (start ? SHIFT : IDLE)
              : state_q == SHIFT ? (last_fall ? LATCH : SHIFT)
              : (latch_end ? IDLE : LATCH);
  end
  // DS only moves on falling ticks, so it is stable for a full half-period around each rise
  always_comb begin
    sr_nx  = LSB_FIRST ? sr_q >> 1 : sr_q << 1;
    div_d  = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
    cnt_d  = start ? '0 : rise ? cnt_q + 1'b1 : cnt_q;
    sr_d   = start ? bus.data : (fall && !last_fall) ? sr_nx : sr_q;
    ds_d   = start ? (LSB_FIRST ? bus.data[0] : bus.data[DATA_WIDTH-1])
           : (fall && !last_fall) ? (LSB_FIRST ? sr_nx[0] : sr_nx[DATA_WIDTH-1]) : ds_q;
    sh_d   = (tick && state_q == SHIFT) ? !sh_q : sh_q;
    st_d   = last_fall ? 1'b1 : latch_end ? 1'b0 : st_q;
    busy_d = start ? 1'b1 : latch_end ? 1'b0 : busy_q;
    done_d = latch_end;
  end
  always_comb begin
    bus.sh_cp = sh_q;
    bus.st_cp = st_q;
    bus.ds    = ds_q;
    bus.busy  = busy_q;
    bus.done  = done_q;
  end
endmodule
